mcode_issue_ctl: RTL and testbench

Issue controller for the GPU/DSP decode stage. It accepts 16-bit instruction words from the prefetch queue, drives the 6-bit opcode into the external registered microcode ROM (1-cycle read latency, 27-bit control word) and presents control word plus register fields to the execute stage over a valid/ready handshake. It also holds issue while a divide or a load/store is outstanding. One instance sits between the prefetch queue and the execute stage in each of GPU and DSP; JERRY selects the DSP opcode map.

---
 rtl/mcode_pkg.sv | 29 ++
 rtl/mcode_opclass.sv | 24 ++
 rtl/mcode_issue_ctl.sv | 126 ++++++++++++
 tb/tb_mcode_issue_ctl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcode_pkg.sv
// Shared opcode constants, op-class and issue-state types for the microcode issue controller.
package mcode_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CTL_W = 27;
    localparam int unsigned CNT_W = 6;

    localparam logic [OP_W-1:0] OP_DIV         = 6'h15;
    localparam logic [OP_W-1:0] OP_LOAD_LO     = 6'h27;
    localparam logic [OP_W-1:0] OP_LOAD_HI     = 6'h2C;
    localparam logic [OP_W-1:0] OP_LOAD_X0     = 6'h3A;
    localparam logic [OP_W-1:0] OP_LOAD_X1     = 6'h3B;
    localparam logic [OP_W-1:0] OP_STORE_LO    = 6'h2D;
    localparam logic [OP_W-1:0] OP_STORE_HI    = 6'h32;
    localparam logic [OP_W-1:0] OP_STORE_X0    = 6'h3C;
    localparam logic [OP_W-1:0] OP_STORE_X1    = 6'h3D;
    // Opcodes the DSP map reuses for non-memory operations.
    localparam logic [OP_W-1:0] OP_DSP_NOLOAD  = 6'h2A;
    localparam logic [OP_W-1:0] OP_DSP_NOSTORE = 6'h30;

    typedef enum logic [1:0] {CLS_ALU, CLS_DIV, CLS_LOAD, CLS_STORE} op_cls_e;
    typedef enum logic [1:0] {RUN, DIVW, MEMW} state_e;

    function automatic logic is_mem(input op_cls_e cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/mcode_opclass.sv
// Combinational opcode to op-class decode; JERRY selects the DSP opcode map.
module mcode_opclass
    import mcode_pkg::*;
#(
    parameter bit JERRY = 1'b0
) (
    input  logic [OP_W-1:0] op,
    output op_cls_e         cls
);

    always_comb begin
        cls = CLS_ALU;
        if (op == OP_DIV) begin
            cls = CLS_DIV;
        end else if ((op >= OP_LOAD_LO && op <= OP_LOAD_HI) ||
                     op == OP_LOAD_X0 || op == OP_LOAD_X1) begin
            if (!(JERRY && op == OP_DSP_NOLOAD)) cls = CLS_LOAD;
        end else if ((op >= OP_STORE_LO && op <= OP_STORE_HI) ||
                     op == OP_STORE_X0 || op == OP_STORE_X1) begin
            if (!(JERRY && op == OP_DSP_NOSTORE)) cls = CLS_STORE;
        end
    end

endmodule

// File: rtl/mcode_issue_ctl.sv
// Decode-stage issue controller: drives the microcode ROM address, presents control word plus
// register fields to execute, and holds issue while a divide or load/store is outstanding.
module mcode_issue_ctl
    import mcode_pkg::*;
#(
    parameter bit          JERRY      = 1'b0,
    parameter int unsigned DIV_CYCLES = 16
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [15:0]       in_instr,
    output logic              in_ready,
    output logic [OP_W-1:0]   rom_a,
    input  logic [CTL_W-1:0]  rom_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTL_W-1:0]  out_ctl,
    output logic [OP_W-1:0]   out_op,
    output logic [REG_W-1:0]  out_reg1,
    output logic [REG_W-1:0]  out_reg2,
    input  logic              mem_done,
    input  logic              flush,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lk_vld_q, lk_vld_d;
    logic               z_ok_q, z_ok_d;
    logic [OP_W-1:0]    lk_op_q, lk_op_d;
    logic [REG_W-1:0]   lk_reg1_q, lk_reg1_d;
    logic [REG_W-1:0]   lk_reg2_q, lk_reg2_d;
    logic               issue, accept;
    op_cls_e            lk_cls;

    mcode_opclass #(
        .JERRY (JERRY)
    ) u_opclass (
        .op  (lk_op_q),
        .cls (lk_cls)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            lk_vld_q  <= 1'b0;
            z_ok_q    <= 1'b0;
            lk_op_q   <= '0;
            lk_reg1_q <= '0;
            lk_reg2_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lk_vld_q  <= lk_vld_d;
            z_ok_q    <= z_ok_d;
            lk_op_q   <= lk_op_d;
            lk_reg1_q <= lk_reg1_d;
            lk_reg2_q <= lk_reg2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (issue) begin
                    if (lk_cls == CLS_DIV) begin
                        state_d = DIVW;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    end else if (is_mem(lk_cls)) begin
                        state_d = MEMW;
                    end
                end
            end
            DIVW: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            MEMW: begin
                if (mem_done) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Lookup slot. A reload in the issue cycle already addressed the ROM with the new opcode,
    // so its control word is valid next cycle; a load into an idle slot waits one cycle.
    always_comb begin
        lk_vld_d  = lk_vld_q;
        z_ok_d    = lk_vld_q;
        lk_op_d   = lk_op_q;
        lk_reg1_d = lk_reg1_q;
        lk_reg2_d = lk_reg2_q;
        if (accept) begin
            lk_vld_d  = 1'b1;
            z_ok_d    = issue;
            lk_op_d   = in_instr[15:10];
            lk_reg1_d = in_instr[9:5];
            lk_reg2_d = in_instr[4:0];
        end else if (issue) begin
            lk_vld_d = 1'b0;
            z_ok_d   = 1'b0;
        end
        if (flush) begin
            lk_vld_d = 1'b0;
            z_ok_d   = 1'b0;
        end
    end

    always_comb begin
        out_valid = lk_vld_q && z_ok_q && (state_q == RUN);
        issue     = out_valid && out_ready;
        in_ready  = !flush && (!lk_vld_q || issue);
        accept    = in_valid && in_ready;
        rom_a     = accept ? in_instr[15:10] : lk_op_q;
        busy      = (state_q != RUN);
        out_ctl   = rom_z;
        out_op    = lk_op_q;
        out_reg1  = lk_reg1_q;
        out_reg2  = lk_reg2_q;
    end

endmodule

// File: tb/tb_mcode_issue_ctl.sv
// Directed bench for mcode_issue_ctl: GPU and DSP instances with registered ROM image models.
module tb_mcode_issue_ctl;
    import mcode_pkg::*;

    logic        sys_clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        g_in_valid, g_in_ready, g_out_valid, g_out_ready, g_mem_done, g_flush, g_busy;
    logic [15:0] g_in_instr;
    logic [5:0]  g_rom_a, g_out_op;
    logic [26:0] g_rom_z, g_out_ctl;
    logic [4:0]  g_out_reg1, g_out_reg2;

    logic        d_in_valid, d_in_ready, d_out_valid, d_busy;
    logic [15:0] d_in_instr;
    logic [5:0]  d_rom_a, d_out_op;
    logic [26:0] d_rom_z, d_out_ctl;
    logic [4:0]  d_out_reg1, d_out_reg2;

    logic [5:0]  cls_op;
    op_cls_e     cls_gpu, cls_dsp;

    always #5 sys_clk = ~sys_clk;

    function automatic logic [26:0] rom_img(input bit dsp, input logic [5:0] a);
        logic [26:0] v;
        case (a)
            6'h00:   v = 27'h0061800;
            6'h01:   v = 27'h0061880;
            6'h02:   v = 27'h0071800;
            default: v = {a, 15'h1234, a};
        endcase
        if (dsp && a == 6'h2A) v = 27'h0069822;
        return v;
    endfunction

    always @(posedge sys_clk) g_rom_z <= rom_img(1'b0, g_rom_a);
    always @(posedge sys_clk) d_rom_z <= rom_img(1'b1, d_rom_a);

    mcode_issue_ctl #(.JERRY(1'b0), .DIV_CYCLES(16)) u_gpu (
        .sys_clk (sys_clk), .reset (reset),
        .in_valid (g_in_valid), .in_instr (g_in_instr), .in_ready (g_in_ready),
        .rom_a (g_rom_a), .rom_z (g_rom_z),
        .out_valid (g_out_valid), .out_ready (g_out_ready), .out_ctl (g_out_ctl),
        .out_op (g_out_op), .out_reg1 (g_out_reg1), .out_reg2 (g_out_reg2),
        .mem_done (g_mem_done), .flush (g_flush), .busy (g_busy)
    );

    mcode_issue_ctl #(.JERRY(1'b1), .DIV_CYCLES(16)) u_dsp (
        .sys_clk (sys_clk), .reset (reset),
        .in_valid (d_in_valid), .in_instr (d_in_instr), .in_ready (d_in_ready),
        .rom_a (d_rom_a), .rom_z (d_rom_z),
        .out_valid (d_out_valid), .out_ready (1'b1), .out_ctl (d_out_ctl),
        .out_op (d_out_op), .out_reg1 (d_out_reg1), .out_reg2 (d_out_reg2),
        .mem_done (1'b0), .flush (1'b0), .busy (d_busy)
    );

    mcode_opclass #(.JERRY(1'b0)) u_cls_gpu (.op (cls_op), .cls (cls_gpu));
    mcode_opclass #(.JERRY(1'b1)) u_cls_dsp (.op (cls_op), .cls (cls_dsp));

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        g_in_valid = 1'b0; g_in_instr = '0; g_out_ready = 1'b1; g_mem_done = 1'b0;
        g_flush = 1'b0; d_in_valid = 1'b0; d_in_instr = '0; cls_op = '0;
        cyc(); cyc();
        reset = 1'b0; #1;
        chk("rst_out_valid", 32'(g_out_valid), 0);
        chk("rst_in_ready", 32'(g_in_ready), 1);
        chk("rst_busy", 32'(g_busy), 0);
        chk("rst_rom_a", 32'(g_rom_a), 0);

        // Single ADD: accepted cycle 1, presented cycle 3.
        cyc(); g_in_valid = 1'b1; g_in_instr = 16'h0000; #1;
        chk("add_in_ready_c1", 32'(g_in_ready), 1);
        chk("add_out_valid_c1", 32'(g_out_valid), 0);
        cyc(); g_in_valid = 1'b0; #1;
        chk("add_out_valid_c2", 32'(g_out_valid), 0);
        cyc(); #1;
        chk("add_out_valid_c3", 32'(g_out_valid), 1);
        chk("add_out_ctl_c3", 32'(g_out_ctl), 32'h0061800);
        chk("add_in_ready_c3", 32'(g_in_ready), 1);
        cyc(); #1;
        chk("add_drained", 32'(g_out_valid), 0);
        // mem_done in RUN is ignored.
        g_mem_done = 1'b1; cyc(); g_mem_done = 1'b0; #1;
        chk("stray_mem_done_busy", 32'(g_busy), 0);

        // Back-to-back stream of three ALU ops.
        cyc(); g_in_valid = 1'b1; g_in_instr = 16'h0000;
        cyc(); g_in_instr = 16'h0420; #1;
        chk("strm_fill", 32'(g_out_valid), 0);
        cyc(); #1;
        chk("strm0_valid", 32'(g_out_valid), 1);
        chk("strm0_ctl", 32'(g_out_ctl), 32'h0061800);
        chk("strm0_in_ready", 32'(g_in_ready), 1);
        cyc(); g_in_instr = 16'h0800; #1;
        chk("strm1_valid", 32'(g_out_valid), 1);
        chk("strm1_ctl", 32'(g_out_ctl), 32'h0061880);
        chk("strm1_reg1", 32'(g_out_reg1), 1);
        cyc(); g_in_valid = 1'b0; #1;
        chk("strm2_valid", 32'(g_out_valid), 1);
        chk("strm2_ctl", 32'(g_out_ctl), 32'h0071800);
        cyc(); #1;
        chk("strm_end", 32'(g_out_valid), 0);

        // DIV followed by a queued ADD: ADD appears 17 cycles after the DIV handshake.
        cyc(); g_in_valid = 1'b1; g_in_instr = 16'h5400;
        cyc(); g_in_instr = 16'h0000;
        cyc(); #1;
        chk("div_valid", 32'(g_out_valid), 1);
        chk("div_op", 32'(g_out_op), 32'h15);
        chk("div_busy_hs", 32'(g_busy), 0);
        for (int i = 1; i <= 16; i++) begin
            cyc(); g_in_valid = 1'b0; #1;
            chk($sformatf("div_busy_%0d", i), 32'(g_busy), 1);
            chk($sformatf("div_hold_%0d", i), 32'(g_out_valid), 0);
        end
        cyc(); #1;
        chk("div_after_busy", 32'(g_busy), 0);
        chk("div_after_valid", 32'(g_out_valid), 1);
        chk("div_after_op", 32'(g_out_op), 0);
        cyc(); #1;
        chk("div_after_drain", 32'(g_out_valid), 0);

        // LOAD 0x29 (reg1=5, reg2=3), ADD queued, mem_done 5 cycles after the handshake.
        cyc(); g_in_valid = 1'b1; g_in_instr = 16'hA4A3;
        cyc(); g_in_instr = 16'h0000;
        cyc(); #1;
        chk("ld_valid", 32'(g_out_valid), 1);
        chk("ld_op", 32'(g_out_op), 32'h29);
        chk("ld_reg1", 32'(g_out_reg1), 5);
        chk("ld_reg2", 32'(g_out_reg2), 3);
        for (int i = 1; i <= 4; i++) begin
            cyc(); g_in_valid = 1'b0; #1;
            chk($sformatf("ld_busy_%0d", i), 32'(g_busy), 1);
            chk($sformatf("ld_hold_%0d", i), 32'(g_out_valid), 0);
        end
        cyc(); g_mem_done = 1'b1; #1;
        chk("ld_done_busy", 32'(g_busy), 1);
        chk("ld_done_hold", 32'(g_out_valid), 0);
        cyc(); g_mem_done = 1'b0; #1;
        chk("ld_after_busy", 32'(g_busy), 0);
        chk("ld_after_valid", 32'(g_out_valid), 1);
        chk("ld_after_op", 32'(g_out_op), 0);
        cyc(); #1;
        chk("ld_after_drain", 32'(g_out_valid), 0);

        // Back-pressure: out_ready low for 10 cycles with a competing input offered.
        g_out_ready = 1'b0;
        cyc(); g_in_valid = 1'b1; g_in_instr = 16'h0420;
        cyc(); g_in_instr = 16'h0800;
        cyc(); #1;
        chk("stall_first_valid", 32'(g_out_valid), 1);
        for (int i = 1; i <= 10; i++) begin
            chk($sformatf("stall_valid_%0d", i), 32'(g_out_valid), 1);
            chk($sformatf("stall_ctl_%0d", i), 32'(g_out_ctl), 32'h0061880);
            chk($sformatf("stall_rom_a_%0d", i), 32'(g_rom_a), 1);
            chk($sformatf("stall_in_ready_%0d", i), 32'(g_in_ready), 0);
            cyc(); #1;
        end
        g_out_ready = 1'b1; g_in_valid = 1'b0;
        cyc(); #1;
        chk("stall_release", 32'(g_out_valid), 0);

        // Flush an ADD held in L while a LOAD is outstanding.
        cyc(); g_in_valid = 1'b1; g_in_instr = 16'hA400;
        cyc(); g_in_instr = 16'h0000;
        cyc(); #1;
        chk("fl_ld_valid", 32'(g_out_valid), 1);
        cyc(); g_in_valid = 1'b0; #1;
        chk("fl_memw_busy", 32'(g_busy), 1);
        cyc(); g_flush = 1'b1; #1;
        chk("fl_in_ready", 32'(g_in_ready), 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(); g_flush = 1'b0; #1;
            chk($sformatf("fl_busy_%0d", i), 32'(g_busy), 1);
            chk($sformatf("fl_hold_%0d", i), 32'(g_out_valid), 0);
        end
        cyc(); g_mem_done = 1'b1; #1;
        chk("fl_done_busy", 32'(g_busy), 1);
        cyc(); g_mem_done = 1'b0; #1;
        chk("fl_after_busy", 32'(g_busy), 0);
        chk("fl_add_gone", 32'(g_out_valid), 0);
        chk("fl_in_ready", 32'(g_in_ready), 1);
        cyc(); #1;
        chk("fl_add_gone2", 32'(g_out_valid), 0);

        // Reset in the middle of DIVW.
        cyc(); g_in_valid = 1'b1; g_in_instr = 16'h5400;
        cyc(); g_in_valid = 1'b0;
        cyc(); #1;
        chk("rdiv_valid", 32'(g_out_valid), 1);
        cyc(); cyc(); #1;
        chk("rdiv_busy", 32'(g_busy), 1);
        reset = 1'b1;
        cyc(); #1;
        chk("rdiv_out_valid", 32'(g_out_valid), 0);
        chk("rdiv_busy_clr", 32'(g_busy), 0);
        chk("rdiv_in_ready", 32'(g_in_ready), 1);
        reset = 1'b0;

        // DSP map: 0x2A is ALU, so no MEMW entry.
        cyc(); d_in_valid = 1'b1; d_in_instr = 16'hA800;
        cyc(); d_in_valid = 1'b0;
        cyc(); #1;
        chk("dsp_valid", 32'(d_out_valid), 1);
        chk("dsp_ctl", 32'(d_out_ctl), 32'h0069822);
        cyc(); #1;
        chk("dsp_no_memw", 32'(d_busy), 0);
        chk("dsp_drain", 32'(d_out_valid), 0);

        // Class decode in both maps.
        cls_op = 6'h2A; #1;
        chk("cls_gpu_2a", 32'(cls_gpu), 32'(CLS_LOAD));
        chk("cls_dsp_2a", 32'(cls_dsp), 32'(CLS_ALU));
        cls_op = 6'h30; #1;
        chk("cls_gpu_30", 32'(cls_gpu), 32'(CLS_STORE));
        chk("cls_dsp_30", 32'(cls_dsp), 32'(CLS_ALU));
        cls_op = 6'h3B; #1;
        chk("cls_dsp_3b", 32'(cls_dsp), 32'(CLS_LOAD));
        cls_op = 6'h3D; #1;
        chk("cls_gpu_3d", 32'(cls_gpu), 32'(CLS_STORE));
        cls_op = 6'h15; #1;
        chk("cls_gpu_15", 32'(cls_gpu), 32'(CLS_DIV));
        cls_op = 6'h26; #1;
        chk("cls_gpu_26", 32'(cls_gpu), 32'(CLS_ALU));
        cls_op = 6'h33; #1;
        chk("cls_gpu_33", 32'(cls_gpu), 32'(CLS_ALU));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
